// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and helpers for the data memory arbiter.
//   arb_state_t     : arbiter FSM states
//   NUM_REQUESTERS  : number of requesters the arbiter is built for
//   be_to_mask()    : expands 4 byte enables into a 32-bit bit mask
package data_memory_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   localparam int NUM_REQUESTERS = 2;

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      logic [31:0] mask;
      mask = '0;
      for (int i = 0; i < 4; i++) begin
         mask[i*8 +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of the requester handshakes and the data_memory port.
//   req_*  : request channel, one lane per requester (valid/ready)
//   rsp_*  : response channel, one valid/ready lane per requester, shared rdata
//   mem_*  : connection to the single-port data_memory (combinational read)
// Modports:
//   slave  : the arbiter side
//   master : the requesters plus the memory (the environment around the arbiter)
interface data_memory_arbiter_if
   import data_memory_pkg::*;
#(
   parameter int memory_addr_size = 6
);

   logic [NUM_REQUESTERS-1:0]                       req_valid;
   logic [NUM_REQUESTERS-1:0]                       req_ready;
   logic [NUM_REQUESTERS-1:0][memory_addr_size-1:0] req_addr;
   logic [NUM_REQUESTERS-1:0]                       req_we;
   logic [NUM_REQUESTERS-1:0][3:0]                  req_be;
   logic [NUM_REQUESTERS-1:0][31:0]                 req_wdata;

   logic [NUM_REQUESTERS-1:0]                       rsp_valid;
   logic [NUM_REQUESTERS-1:0]                       rsp_ready;
   logic [31:0]                                     rsp_rdata;

   logic                                            mem_write_enable;
   logic [memory_addr_size-1:0]                     mem_read_reg;
   logic [memory_addr_size-1:0]                     mem_write_reg;
   logic [31:0]                                     mem_write_data;
   logic [31:0]                                     mem_read_data;

   modport slave (
      input  req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready, mem_read_data,
      output req_ready, rsp_valid, rsp_rdata,
             mem_write_enable, mem_read_reg, mem_write_reg, mem_write_data
   );

   modport master (
      output req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready, mem_read_data,
      input  req_ready, rsp_valid, rsp_rdata,
             mem_write_enable, mem_read_reg, mem_write_reg, mem_write_data
   );

endinterface

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
//   req_valid  : request valid per requester
//   last_grant : index granted most recently (held by the parent)
//   grant      : one-hot grant, all zero when nobody requests
//   grant_idx  : index of the granted requester (0 when nobody requests)
module rr_arbiter2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       grant_idx
);

   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      grant_idx = 1'b0;
      grant     = 2'b00;
      if (req_valid == 2'b11) begin
         // Contention: the requester that did not win last time goes now.
         grant_idx = ~last_grant;
      end else if (req_valid[1]) begin
         grant_idx = 1'b1;
      end
      if (req_valid != 2'b00) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the load/store unit (port 0)
// and the debug/loader port (port 1). One transaction in flight at a time:
// IDLE accepts, SERVE reads (and for stores writes back the merged word),
// RESP holds the response until the requester takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester handshakes and data_memory connection (slave side)
module data_memory_arbiter
   import data_memory_pkg::*;
#(
   parameter int memory_addr_size = 6,
   parameter int num_requesters   = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   data_memory_arbiter_if.slave bus
);

   generate
      if (num_requesters != NUM_REQUESTERS) begin : g_bad_num_requesters
         $error("data_memory_arbiter supports exactly 2 requesters");
      end
   endgenerate

   arb_state_t                  state_q, state_d;
   logic                        last_grant_q;
   logic                        grant_q;
   logic [memory_addr_size-1:0] addr_q;
   logic                        we_q;
   logic [3:0]                  be_q;
   logic [31:0]                 wdata_q;
   logic [31:0]                 rdata_q;

   logic [1:0]                  arb_grant;
   logic                        arb_idx;
   logic                        accept;
   logic [1:0]                  req_ready_c;
   logic [1:0]                  rsp_valid_c;
   logic                        mem_we_c;
   logic [31:0]                 mem_wdata_c;
   logic [31:0]                 wmask;

   rr_arbiter2 u_rr_arbiter2 (
      .req_valid  (bus.req_valid),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .grant_idx  (arb_idx)
   );

   assign wmask = be_to_mask(be_q);

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      req_ready_c = 2'b00;
      rsp_valid_c = 2'b00;
      mem_we_c    = 1'b0;
      mem_wdata_c = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid != 2'b00) begin
               req_ready_c = arb_grant;
               accept      = 1'b1;
               state_d     = SERVE;
            end
         end
         SERVE: begin
            // The memory writes whole words only, so sub-word stores merge
            // the bytes being kept from the word read this same cycle.
            if (we_q && (be_q != 4'b0000)) begin
               mem_we_c    = 1'b1;
               mem_wdata_c = (bus.mem_read_data & ~wmask) | (wdata_q & wmask);
            end
            state_d = RESP;
         end
         RESP: begin
            rsp_valid_c[grant_q] = 1'b1;
            if (bus.rsp_ready[grant_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // The state register already sits in IDLE under reset, but IDLE raises
      // req_ready from live inputs; hold every handshake output low instead.
      if (!rst_n) begin
         accept      = 1'b0;
         req_ready_c = 2'b00;
         rsp_valid_c = 2'b00;
         mem_we_c    = 1'b0;
         mem_wdata_c = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         be_q         <= 4'b0000;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_grant_q <= arb_idx;
            grant_q      <= arb_idx;
            addr_q       <= bus.req_addr[arb_idx];
            we_q         <= bus.req_we[arb_idx];
            be_q         <= bus.req_be[arb_idx];
            wdata_q      <= bus.req_wdata[arb_idx];
         end
         if (state_q == SERVE) begin
            rdata_q <= bus.mem_read_data;
         end
      end
   end

   assign bus.req_ready        = req_ready_c;
   assign bus.rsp_valid        = rsp_valid_c;
   assign bus.rsp_rdata        = rdata_q;
   assign bus.mem_write_enable = mem_we_c;
   assign bus.mem_write_data   = mem_wdata_c;
   assign bus.mem_read_reg     = addr_q;
   assign bus.mem_write_reg    = addr_q;

endmodule
